led_pwm_bank: RTL and testbench
===============================

# led_pwm_bank

Parametrised multi-channel LED driver for the icestick LED bank (D1..D5), replacing the fixed single-LED `top` output. A shared prescaled PWM counter drives per-channel brightness. Each channel runs in one of four modes: OFF, ON, BLINK or BREATHE. Configuration is written one channel at a time by the enclosing design. New levels apply only at PWM period boundaries, so the outputs never glitch.

## Interface

- `CHANNELS`, 5, number of LED outputs (1..16)
- `PWM_BITS`, 8, PWM resolution; period is 2^PWM_BITS ticks
- `PRESCALE`, 47, clocks per PWM tick (>=1)
- `BLINK_PERIODS`, 64, PWM periods per blink half-phase (>=1)

- `clk`  in  1  system clock (12 MHz on icestick)
- `rstn`  in  1  synchronous, active-low reset
- `cfg_we`  in  1  config write strobe, one cycle
- `cfg_ch`  in  4  target channel index
- `cfg_mode`  in  2  0=OFF, 1=ON, 2=BLINK, 3=BREATHE
- `cfg_duty`  in  PWM_BITS  brightness / breathe peak
- `led`  out  CHANNELS  LED drive, active high, registered
- `period_start`  out  1  one-cycle pulse at each PWM period start

## Operation

- Reset (`rstn`=0 at a rising edge): all modes OFF, duties 0, levels 0, ramps 0 with direction up, counters 0, blink phase 0. `led`=0 and `period_start`=0.
- Prescaler `pre_cnt` counts 0..PRESCALE-1. `tick` is asserted when `pre_cnt`==PRESCALE-1.
- `pwm_cnt` (PWM_BITS wide) increments on `tick` and wraps from 2^PWM_BITS-1 to 0.
- Boundary event `bnd` = `tick` && `pwm_cnt`==all-ones. On the edge where `bnd` is asserted:
  - `pwm_cnt` goes to 0.
  - `period_start` goes to 1 for exactly one cycle.
  - Every channel's `level` is reloaded.
- Level per mode, evaluated with register values from before the edge:
  - OFF: 0.
  - ON: duty.
  - BLINK: duty when blink phase is 1, otherwise 0.
  - BREATHE: current ramp value, after the ramp update below.
- Blink: one shared period counter runs 0..BLINK_PERIODS-1, advancing on `bnd`. When it wraps, blink phase toggles.
- Breathe (per channel, on `bnd`):
  - Direction up and ramp<duty: ramp+1. Direction up and ramp>=duty: direction flips to down, ramp-1 (ramp holds if it is 0).
  - Direction down and ramp>0: ramp-1. Direction down and ramp==0: direction flips to up, ramp+1 (ramp holds if duty is 0).
  - Net effect: a triangle wave 0..duty..0. Duty 0 keeps ramp at 0.
- Output: `led[i]` registers (`pwm_cnt` < `level[i]`). Duty D lights the LED for D of every 2^PWM_BITS ticks. Full-on is not reachable; maximum is (2^PWM_BITS-1)/2^PWM_BITS.
- Config write (`cfg_we`=1):
  - If `cfg_ch` < CHANNELS: store mode and duty for that channel, and clear its ramp to 0 with direction up.
  - If `cfg_ch` >= CHANNELS: the write is ignored and no state changes.
  - `level` is never written directly.
- Channels beyond CHANNELS do not exist. `led` width equals CHANNELS exactly.

## Timing

- Write at cycle t takes effect at the first `bnd` strictly after t.
- A write coinciding with `bnd` misses that boundary and applies at the next one.
- Output latency: `led` at cycle t+1 reflects `pwm_cnt` and `level` at cycle t. The first compare of a new period (`pwm_cnt`=0) appears on `led` one cycle after `period_start`.
- Period length: PRESCALE*2^PWM_BITS clocks. The first `period_start` after reset occurs at clock PRESCALE*2^PWM_BITS (counted from the first clock with `rstn`=1).
- Reset mid-period: all state is cleared on that edge. `led` and `period_start` are 0 the following cycle, and the period restarts from 0.
- Back-to-back writes to the same channel within one period: the last write wins.

## Test plan

Bench parameters: CHANNELS=5, PWM_BITS=4, PRESCALE=1, BLINK_PERIODS=2.

- Reset check: hold `rstn`=0 for 3 cycles, then release -> `led`=5'b0 throughout; `period_start` first pulses 16 cycles after release, then every 16 cycles.
- ON duty, channel 0: write ch0 ON duty 4 -> after the next `period_start`, `led[0]` is high for exactly 4 of every 16 cycles; other LEDs stay 0.
- ON duty edges: duty 0 -> `led[1]` never high; duty 15 -> `led[1]` high 15 of 16 cycles; a write coinciding with `bnd` applies one period later.
- BLINK: write ch2 BLINK duty 8 -> per-period high counts follow 0,0,8,8,0,0,8,8 (phase alignment follows the shared blink counter).
- BREATHE: write ch3 BREATHE duty 3 -> per-period high counts 1,2,3,2,1,0,1,2,... Rewriting the same config restarts the sequence at 1.
- Invalid channel and reset: write `cfg_ch`=7 ON duty 15 -> no `led` change. Assert `rstn`=0 mid-period while ch0 is ON -> `led`=0 on the next cycle and all modes return to OFF.

Source files
------------

// File: rtl/led_pwm_bank.sv
// ----------------------------------------------------------------------------
// led_pwm_bank
//
// Multi-channel LED driver. All channels share one prescaled PWM counter.
// Each channel has its own mode (OFF, ON, BLINK, BREATHE) and duty.
// A channel's PWM level is reloaded only at a PWM period boundary, so a
// configuration change can never produce a partial or glitched period.
//
// Ports
//   clk          system clock
//   rstn         synchronous, active-low reset
//   cfg_we       one-cycle configuration write strobe
//   cfg_ch       target channel; indices >= CHANNELS are silently ignored
//   cfg_mode     0=OFF, 1=ON, 2=BLINK, 3=BREATHE
//   cfg_duty     brightness (ON/BLINK) or ramp peak (BREATHE)
//   led          registered LED drive, active high, one bit per channel
//   period_start one-cycle pulse in the first cycle of every PWM period
// ----------------------------------------------------------------------------
module led_pwm_bank #(
    parameter int CHANNELS      = 5,
    parameter int PWM_BITS      = 8,
    parameter int PRESCALE      = 47,
    parameter int BLINK_PERIODS = 64
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                cfg_we,
    input  logic [3:0]          cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [PWM_BITS-1:0] cfg_duty,
    output logic [CHANNELS-1:0] led,
    output logic                period_start
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BL_W  = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
    localparam logic [BL_W-1:0]  BL_MAX  = BL_W'(BLINK_PERIODS - 1);

    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_ON      = 2'd1;
    localparam logic [1:0] MODE_BLINK   = 2'd2;
    localparam logic [1:0] MODE_BREATHE = 2'd3;

    logic [PRE_W-1:0]    pre_cnt_reg;
    logic [PWM_BITS-1:0] pwm_cnt_reg;
    logic [BL_W-1:0]     blink_cnt_reg;
    logic                blink_phase_reg;
    logic                tick;
    logic                bnd;
    logic [CHANNELS-1:0] led_next;

    assign tick = (pre_cnt_reg == PRE_MAX);
    assign bnd  = tick && (pwm_cnt_reg == '1);

    // Shared timebase: prescaler, PWM counter, blink counter and phase.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pre_cnt_reg     <= '0;
            pwm_cnt_reg     <= '0;
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
            period_start    <= 1'b0;
            led             <= '0;
        end else begin
            pre_cnt_reg  <= tick ? '0 : pre_cnt_reg + 1'b1;
            // Natural wrap from all-ones to zero marks the period boundary.
            if (tick) begin
                pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
            end
            period_start <= bnd;
            if (bnd) begin
                if (blink_cnt_reg == BL_MAX) begin
                    blink_cnt_reg   <= '0;
                    blink_phase_reg <= ~blink_phase_reg;
                end else begin
                    blink_cnt_reg <= blink_cnt_reg + 1'b1;
                end
            end
            led <= led_next;
        end
    end

    // Per-channel configuration, breathe ramp and period level.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [1:0]          mode_reg;
        logic [PWM_BITS-1:0] duty_reg;
        logic [PWM_BITS-1:0] ramp_reg;
        logic [PWM_BITS-1:0] ramp_next;
        logic [PWM_BITS-1:0] level_reg;
        logic [PWM_BITS-1:0] level_next;
        logic                down_reg;
        logic                down_next;
        logic                wr_hit;

        // Out-of-range channel numbers never match any generated channel.
        assign wr_hit = cfg_we && (cfg_ch == 4'(gi));

        // Triangle ramp 0..duty..0; turning points flip the direction and
        // step away from the peak/floor in the same boundary.
        always_comb begin
            ramp_next = ramp_reg;
            down_next = down_reg;
            if (!down_reg) begin
                if (ramp_reg < duty_reg) begin
                    ramp_next = ramp_reg + 1'b1;
                end else begin
                    down_next = 1'b1;
                    if (ramp_reg != '0) begin
                        ramp_next = ramp_reg - 1'b1;
                    end
                end
            end else begin
                if (ramp_reg != '0) begin
                    ramp_next = ramp_reg - 1'b1;
                end else begin
                    down_next = 1'b0;
                    if (duty_reg != '0) begin
                        ramp_next = ramp_reg + 1'b1;
                    end
                end
            end
        end

        always_comb begin
            level_next = '0;
            case (mode_reg)
                MODE_OFF:     level_next = '0;
                MODE_ON:      level_next = duty_reg;
                MODE_BLINK:   level_next = blink_phase_reg ? duty_reg : '0;
                MODE_BREATHE: level_next = ramp_next;
                default:      level_next = '0;
            endcase
        end

        always_ff @(posedge clk) begin
            if (!rstn) begin
                mode_reg  <= MODE_OFF;
                duty_reg  <= '0;
                ramp_reg  <= '0;
                down_reg  <= 1'b0;
                level_reg <= '0;
            end else begin
                // A write on a boundary edge wins over the ramp step; the
                // level for that boundary still uses the old settings.
                if (wr_hit) begin
                    mode_reg <= cfg_mode;
                    duty_reg <= cfg_duty;
                    ramp_reg <= '0;
                    down_reg <= 1'b0;
                end else if (bnd) begin
                    ramp_reg <= ramp_next;
                    down_reg <= down_next;
                end
                if (bnd) begin
                    level_reg <= level_next;
                end
            end
        end

        assign led_next[gi] = (pwm_cnt_reg < level_reg);
    end

endmodule

// File: tb/tb_led_pwm_bank.sv
module tb_led_pwm_bank;

    localparam int CH = 5;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_ch = 4'd0;
    logic [1:0]  cfg_mode = 2'd0;
    logic [3:0]  cfg_duty = 4'd0;
    logic [4:0]  led;
    logic        period_start;

    int pass_cnt = 0;
    int total_cnt = 0;
    int period_cnt [CH];

    always #5 clk = ~clk;

    led_pwm_bank #(
        .CHANNELS(5),
        .PWM_BITS(4),
        .PRESCALE(1),
        .BLINK_PERIODS(2)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .cfg_we(cfg_we),
        .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode),
        .cfg_duty(cfg_duty),
        .led(led),
        .period_start(period_start)
    );

    task automatic do_reset();
        rstn = 1'b0;
        cfg_we = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic cfg_write(input int ch, input int mode, input int duty);
        cfg_ch = 4'(ch);
        cfg_mode = 2'(mode);
        cfg_duty = 4'(duty);
        cfg_we = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
        $display("write ch=%0d mode=%0d duty=%0d", ch, mode, duty);
    endtask

    task automatic wait_ps(output int cycles);
        cycles = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (period_start === 1'b1) begin
                cycles = k;
                break;
            end
        end
        if (cycles == 0) begin
            total_cnt++;
            $display("FAIL wait_ps: period_start not seen, got none required within 40 cycles");
        end
    endtask

    // Count led highs over the 16 cycles of the period that has just started.
    task automatic count_period();
        for (int c = 0; c < CH; c++) period_cnt[c] = 0;
        repeat (16) begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) begin
                if (led[c] === 1'b1) period_cnt[c]++;
            end
        end
        $display("period counts %0d %0d %0d %0d %0d", period_cnt[0], period_cnt[1],
                 period_cnt[2], period_cnt[3], period_cnt[4]);
    endtask

    task automatic test_reset();
        int cycles;
        int led_bad;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (led !== 5'b0) $display("FAIL reset_led: got %b required 00000", led);
        else pass_cnt++;
        total_cnt++;
        if (period_start !== 1'b0) $display("FAIL reset_ps: got %b required 0", period_start);
        else pass_cnt++;
        rstn = 1'b1;
        cycles = 0;
        led_bad = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (led !== 5'b0) led_bad++;
            if (period_start === 1'b1) begin
                cycles = k;
                break;
            end
        end
        total_cnt++;
        if (cycles !== 16) $display("FAIL first_ps: got %0d cycles required 16", cycles);
        else pass_cnt++;
        total_cnt++;
        if (led_bad !== 0) $display("FAIL led_idle: got %0d nonzero cycles required 0", led_bad);
        else pass_cnt++;
        wait_ps(cycles);
        total_cnt++;
        if (cycles !== 16) $display("FAIL ps_interval: got %0d cycles required 16", cycles);
        else pass_cnt++;
        $display("test_reset done");
    endtask

    task automatic test_on();
        int cycles;
        int exp_on [CH] = '{4, 0, 0, 0, 0};
        do_reset();
        cfg_write(0, 1, 4);
        wait_ps(cycles);
        count_period();
        for (int c = 0; c < CH; c++) begin
            total_cnt++;
            if (period_cnt[c] !== exp_on[c])
                $display("FAIL on_ch%0d: got %0d highs required %0d", c, period_cnt[c], exp_on[c]);
            else pass_cnt++;
        end
        count_period();
        total_cnt++;
        if (period_cnt[0] !== 4) $display("FAIL on_repeat: got %0d highs required 4", period_cnt[0]);
        else pass_cnt++;
    endtask

    task automatic test_on_edges();
        int cycles;
        do_reset();
        cfg_write(1, 1, 0);
        wait_ps(cycles);
        count_period();
        total_cnt++;
        if (period_cnt[1] !== 0) $display("FAIL duty0: got %0d highs required 0", period_cnt[1]);
        else pass_cnt++;
        // Mid-period write: current period keeps the old level.
        cfg_write(1, 1, 15);
        for (int c = 0; c < CH; c++) period_cnt[c] = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (led[1] === 1'b1) period_cnt[1]++;
        end
        total_cnt++;
        if (period_cnt[1] !== 0) $display("FAIL midwrite_hold: got %0d highs required 0", period_cnt[1]);
        else pass_cnt++;
        count_period();
        total_cnt++;
        if (period_cnt[1] !== 15) $display("FAIL duty15: got %0d highs required 15", period_cnt[1]);
        else pass_cnt++;
        // Write landing exactly on the boundary edge misses that boundary.
        repeat (15) @(negedge clk);
        cfg_write(1, 1, 2);
        total_cnt++;
        if (period_start !== 1'b1) $display("FAIL bnd_align: got ps=%b required 1", period_start);
        else pass_cnt++;
        count_period();
        total_cnt++;
        if (period_cnt[1] !== 15) $display("FAIL bnd_write_old: got %0d highs required 15", period_cnt[1]);
        else pass_cnt++;
        count_period();
        total_cnt++;
        if (period_cnt[1] !== 2) $display("FAIL bnd_write_new: got %0d highs required 2", period_cnt[1]);
        else pass_cnt++;
    endtask

    task automatic test_blink();
        int cycles;
        int exp_b [8] = '{0, 0, 8, 8, 0, 0, 8, 8};
        do_reset();
        cfg_write(2, 2, 8);
        wait_ps(cycles);
        for (int p = 0; p < 8; p++) begin
            count_period();
            total_cnt++;
            if (period_cnt[2] !== exp_b[p])
                $display("FAIL blink_p%0d: got %0d highs required %0d", p, period_cnt[2], exp_b[p]);
            else pass_cnt++;
        end
    endtask

    task automatic test_breathe();
        int cycles;
        int exp_r [8] = '{1, 2, 3, 2, 1, 0, 1, 2};
        int exp_s [2] = '{1, 2};
        do_reset();
        cfg_write(3, 3, 3);
        wait_ps(cycles);
        for (int p = 0; p < 8; p++) begin
            count_period();
            total_cnt++;
            if (period_cnt[3] !== exp_r[p])
                $display("FAIL breathe_p%0d: got %0d highs required %0d", p, period_cnt[3], exp_r[p]);
            else pass_cnt++;
        end
        cfg_write(3, 3, 3);
        wait_ps(cycles);
        for (int p = 0; p < 2; p++) begin
            count_period();
            total_cnt++;
            if (period_cnt[3] !== exp_s[p])
                $display("FAIL breathe_restart_p%0d: got %0d highs required %0d", p, period_cnt[3], exp_s[p]);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        int cycles;
        do_reset();
        cfg_write(4, 1, 10);
        cfg_write(4, 1, 5);
        wait_ps(cycles);
        count_period();
        total_cnt++;
        if (period_cnt[4] !== 5) $display("FAIL back_to_back: got %0d highs required 5", period_cnt[4]);
        else pass_cnt++;
    endtask

    task automatic test_invalid_reset();
        int cycles;
        int exp_i [CH] = '{4, 0, 0, 0, 0};
        do_reset();
        cfg_write(0, 1, 4);
        cfg_write(7, 1, 15);
        wait_ps(cycles);
        count_period();
        for (int c = 0; c < CH; c++) begin
            total_cnt++;
            if (period_cnt[c] !== exp_i[c])
                $display("FAIL invalid_ch%0d: got %0d highs required %0d", c, period_cnt[c], exp_i[c]);
            else pass_cnt++;
        end
        repeat (2) @(negedge clk);
        total_cnt++;
        if (led[0] !== 1'b1) $display("FAIL pre_reset_led: got %b required 1", led[0]);
        else pass_cnt++;
        rstn = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (led !== 5'b0) $display("FAIL midreset_led: got %b required 00000", led);
        else pass_cnt++;
        total_cnt++;
        if (period_start !== 1'b0) $display("FAIL midreset_ps: got %b required 0", period_start);
        else pass_cnt++;
        rstn = 1'b1;
        wait_ps(cycles);
        total_cnt++;
        if (cycles !== 16) $display("FAIL restart_ps: got %0d cycles required 16", cycles);
        else pass_cnt++;
        count_period();
        total_cnt++;
        if (period_cnt[0] !== 0) $display("FAIL mode_cleared: got %0d highs required 0", period_cnt[0]);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_on();
        test_on_edges();
        test_blink();
        test_breathe();
        test_back_to_back();
        test_invalid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
